// File: rtl/mnist_frame_reader.sv
// mnist_frame_reader: read side of the 28x28 binary MNIST frame buffer.
// On each vsync falling edge the whole grid is read through the buffer's
// registered read port, packed into row words and streamed to the classifier
// over valid/ready. Per-frame ink count and an empty-frame flag are reported.
module mnist_frame_reader #(
    parameter int GRID    = 28,
    parameter int ADDR_W  = 10,
    parameter int MIN_INK = 16
) (
    input  logic              dclk,
    input  logic              rst_n,
    input  logic              vsync,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic              ram_rd_data,
    output logic [GRID-1:0]   row_data,
    output logic [4:0]        row_idx,
    output logic              row_valid,
    input  logic              row_ready,
    output logic              row_last,
    output logic [ADDR_W-1:0] ink_count,
    output logic              frame_empty,
    output logic              frame_done,
    output logic              frame_dropped,
    output logic              busy
);
    localparam int CNT_W = $clog2(GRID + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_READ    = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(GRID);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [4:0]        ROW_LAST = 5'(GRID - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(GRID);
    localparam logic [ADDR_W-1:0] MIN_A    = ADDR_W'(MIN_INK);

    logic [1:0]        r_state;
    logic              r_vsync_d;
    logic [4:0]        r_row;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_acc;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_ink;
    logic [GRID-1:0]   r_row_data;
    logic              r_empty;
    logic              r_done;
    logic              r_dropped;

    logic              w_frame_end;
    logic              w_rd;
    logic [ADDR_W-1:0] w_addr;

    // Falling edge of the capture window; a read is issued for cnt 0..GRID-1,
    // the extra READ cycle only collects the last registered read result.
    assign w_frame_end = r_vsync_d & ~vsync;
    assign w_rd        = (r_state == S_READ) && (r_cnt < CNT_LAST);
    assign w_addr      = ADDR_W'(r_row) * STRIDE + ADDR_W'(r_cnt);

    assign ram_rd_en     = w_rd;
    assign ram_rd_addr   = w_rd ? w_addr : r_addr;
    assign row_data      = r_row_data;
    assign row_idx       = r_row;
    assign row_valid     = (r_state == S_PRESENT);
    assign row_last      = (r_state == S_PRESENT) && (r_row == ROW_LAST);
    assign ink_count     = r_ink;
    assign frame_empty   = r_empty;
    assign frame_done    = r_done;
    assign frame_dropped = r_dropped;
    assign busy          = (r_state != S_IDLE);

    // vsync history and the single-cycle status pulses
    always_ff @(posedge dclk) begin
        if (!rst_n) begin
            r_vsync_d <= 1'b0;
            r_dropped <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            r_dropped <= w_frame_end && (r_state != S_IDLE);
            r_done    <= (r_state == S_DONE);
        end
    end

    // Readout sequencer: row/column walk and handshake with the classifier
    always_ff @(posedge dclk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_row   <= 5'd0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_frame_end) begin
                        r_state <= S_READ;
                        r_row   <= 5'd0;
                        r_cnt   <= '0;
                    end
                end
                S_READ: begin
                    if (r_cnt == CNT_LAST) r_state <= S_PRESENT;
                    else                   r_cnt   <= r_cnt + CNT_ONE;
                end
                S_PRESENT: begin
                    if (row_ready) begin
                        if (r_row == ROW_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_row   <= r_row + 5'd1;
                            r_cnt   <= '0;
                            r_state <= S_READ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read datapath: held address, row packing and the ink accumulator
    always_ff @(posedge dclk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_row_data <= '0;
            r_acc      <= '0;
        end else begin
            if (w_rd) r_addr <= w_addr;
            if (r_state == S_IDLE && w_frame_end) r_acc <= '0;
            // data returned now belongs to the read issued at cnt-1
            if (r_state == S_READ && r_cnt != '0) begin
                r_row_data[r_cnt - CNT_ONE] <= ram_rd_data;
                r_acc <= r_acc + ADDR_W'(ram_rd_data);
            end
        end
    end

    // Frame results, latched once per completed readout
    always_ff @(posedge dclk) begin
        if (!rst_n) begin
            r_ink   <= '0;
            r_empty <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_ink   <= r_acc;
            r_empty <= (r_acc < MIN_A);
        end
    end

endmodule

// File: tb/tb_mnist_frame_reader.sv
// Bench for mnist_frame_reader: frame-buffer model with a registered read
// port, directed frames with hand-computed row words and ink results, and a
// scoreboard monitor that checks every accepted row and every frame_done.
module tb_mnist_frame_reader;
    logic        dclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        ram_rd_en;
    logic [9:0]  ram_rd_addr;
    logic        ram_rd_data = 1'b0;
    logic [27:0] row_data;
    logic [4:0]  row_idx;
    logic        row_valid;
    logic        row_ready = 1'b1;
    logic        row_last;
    logic [9:0]  ink_count;
    logic        frame_empty;
    logic        frame_done;
    logic        frame_dropped;
    logic        busy;

    mnist_frame_reader dut (
        .dclk(dclk), .rst_n(rst_n), .vsync(vsync),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
        .row_ready(row_ready), .row_last(row_last),
        .ink_count(ink_count), .frame_empty(frame_empty), .frame_done(frame_done),
        .frame_dropped(frame_dropped), .busy(busy)
    );

    always #5 dclk = ~dclk;

    int cyc = 0;
    always @(posedge dclk) cyc <= cyc + 1;

    // frame buffer with a registered read port
    logic mem [0:1023];
    always @(posedge dclk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

    typedef struct { logic [27:0] d; int idx; bit last; } row_t;
    typedef struct { int ink; bit empty; } res_t;
    row_t row_q[$];
    res_t res_q[$];

    int n_cmp = 0, n_err = 0;
    int done_cnt = 0, drop_cnt = 0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // scoreboard monitor: rows on handshake, results on frame_done
    initial forever begin
        @(negedge dclk);
        if (row_valid && row_ready) begin
            if (row_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL row_unexpected: got row %0d expected none", row_idx);
            end else begin
                row_t e;
                e = row_q.pop_front();
                check("row_idx", row_idx, e.idx);
                check("row_data", row_data, e.d);
                check("row_last", row_last, e.last);
            end
        end
        if (frame_done) begin
            done_cnt++;
            if (res_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL done_unexpected: got frame_done expected none");
            end else begin
                res_t r;
                r = res_q.pop_front();
                check("ink_count", ink_count, r.ink);
                check("frame_empty", frame_empty, r.empty);
            end
        end
        if (frame_dropped) drop_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // 0 zeros, 1 checkerboard, 2 ones, 3 sixteen ink cells, 4 fifteen ink cells
    task automatic fill(input int pat);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
                logic b;
                case (pat)
                    1:       b = ((r + c) % 2) == 1;
                    2:       b = 1'b1;
                    3:       b = (r == 0) && (c < 16);
                    4:       b = (r == 0) && (c < 15);
                    default: b = 1'b0;
                endcase
                mem[r*28 + c] = b;
            end
    endtask

    function automatic logic [27:0] exp_row(input int pat, input int r);
        case (pat)
            1:       return (r % 2 == 1) ? 28'h5555555 : 28'hAAAAAAA;
            2:       return 28'hFFFFFFF;
            3:       return (r == 0) ? 28'h000FFFF : 28'h0;
            4:       return (r == 0) ? 28'h0007FFF : 28'h0;
            default: return 28'h0;
        endcase
    endfunction

    // Runs one frame. stall_row is held off stall_n cycles; vs_row gets a second
    // vsync falling edge while presented; rst_row gets a 1-cycle reset mid-read.
    task automatic run_frame(input int pat, input int ink, input bit empty,
                             input int stall_row, input int stall_n,
                             input int vs_row, input int rst_row);
        int t0, n, stalls, vs_ph;
        bit done, aborted, first_rd, first_v, post;
        logic [27:0] held;
        t0 = 0; stalls = 0; vs_ph = 0;
        done = 0; aborted = 0; first_rd = 0; first_v = 0; post = 0; held = '0;
        fill(pat);
        for (int r = 0; r < 28; r++)
            if (rst_row < 0 || r < rst_row) begin
                row_t e;
                e.d = exp_row(pat, r); e.idx = r; e.last = (r == 27);
                row_q.push_back(e);
            end
        if (rst_row < 0) begin
            res_t x;
            x.ink = ink; x.empty = empty;
            res_q.push_back(x);
        end
        done_cnt = 0; drop_cnt = 0;
        @(posedge dclk); #1 vsync = 1'b1;
        repeat (2) @(posedge dclk);
        #1 vsync = 1'b0; t0 = cyc;
        for (int k = 0; k < 3000; k++) begin
            @(posedge dclk); #1;
            n = cyc - t0;
            if (post) begin
                check("resume_rd_en", ram_rd_en, 1);
                check("resume_addr", ram_rd_addr, (stall_row + 1) * 28);
                post = 0;
            end
            if (ram_rd_en && !first_rd) begin
                first_rd = 1;
                check("first_rd_cycle", n, 1);
                check("first_rd_addr", ram_rd_addr, 0);
            end
            if (row_valid && !first_v) begin
                first_v = 1;
                check("row0_valid_cycle", n, 30);
            end
            if (rst_row >= 0 && ram_rd_en && ram_rd_addr == 10'(rst_row * 28 + 5)) begin
                rst_n = 1'b0;
                @(posedge dclk); #1;
                check("reset_outputs", {ram_rd_en, ram_rd_addr, row_data, row_idx, row_valid,
                      row_last, ink_count, frame_empty, frame_done, frame_dropped, busy}, 0);
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
            if (frame_done) begin
                check("done_cycle", n, 842 + stall_n);
                check("busy_at_done", busy, 0);
                done = 1;
                break;
            end
            if (vs_row >= 0 && row_valid && row_idx == 5'(vs_row)) begin
                if (vs_ph == 0) begin vsync = 1'b1; vs_ph = 1; end
                else if (vs_ph == 1) begin vsync = 1'b0; vs_ph = 2; end
            end
            if (stall_n > 0 && row_valid && row_idx == 5'(stall_row)) begin
                if (stalls == 0) held = row_data;
                else begin
                    check("stall_data_stable", row_data, held);
                    check("stall_no_rd", ram_rd_en, 0);
                end
                if (stalls < stall_n) begin
                    row_ready = 1'b0; stalls++;
                end else begin
                    row_ready = 1'b1; post = 1;
                end
            end else begin
                row_ready = 1'b1;
            end
        end
        row_ready = 1'b1;
        if (!done && !aborted) check("frame_timeout", n, 842 + stall_n);
        repeat (aborted ? 50 : 3) @(posedge dclk);
        #1;
        check("done_count", done_cnt, aborted ? 0 : 1);
        check("drop_count", drop_cnt, (vs_row >= 0) ? 1 : 0);
        check("idle_after", busy, 0);
        check("rows_left", row_q.size(), 0);
    endtask

    initial begin
        fill(0);
        repeat (3) @(posedge dclk);
        #1 rst_n = 1'b1;
        check("reset_state", {ram_rd_en, ram_rd_addr, row_data, row_idx, row_valid,
              row_last, ink_count, frame_empty, frame_done, frame_dropped, busy}, 0);
        run_frame(0, 0,   1'b1, -1, 0,  -1, -1);  // blank frame, latency checks
        run_frame(1, 392, 1'b0,  3, 10, -1, -1);  // checkerboard, stall on row 3
        run_frame(1, 392, 1'b0, 10, 3,  10, -1);  // second frame end on row 10
        run_frame(2, 0,   1'b0, -1, 0,  -1, 5);   // reset during READ of row 5
        run_frame(2, 784, 1'b0, -1, 0,  -1, -1);  // full ink, restart at addr 0
        run_frame(3, 16,  1'b0, -1, 0,  -1, -1);  // ink exactly MIN_INK
        run_frame(4, 15,  1'b1, -1, 0,  -1, -1);  // one below MIN_INK
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
